// File: rtl/xor_result_collector.sv
// -----------------------------------------------------------------------------
// xor_result_collector
//
// Receive side of the AddRoundKey XOR-unit interface. Accepts one 40-bit column
// result per valid/ready beat, strips the pad-lane byte (optionally checking
// that it is zero), reassembles the 128-bit round state column-major and hands
// it on through a one-entry output buffer.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous discard of any partially assembled state
//   in_valid     column result present
//   in_ready     column accepted this cycle (combinational from out_ready)
//   in_data      [39:8] rows 0..3 of the column, [7:0] pad-lane result
//   out_valid    out_state holds a complete state
//   out_ready    downstream consumes out_state
//   out_state    assembled state; byte 4c+r (column c, row r) at [127-8k -: 8]
//   out_pad_err  a pad byte of this state was nonzero; qualified by out_valid
//
// Configuration:
//   XOR_PAD_CHECK_EN  when defined, nonzero pad bytes are flagged on
//                     out_pad_err; when undefined, in_data[7:0] is ignored and
//                     out_pad_err is tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module xor_result_collector (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [39:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_pad_err
);

  logic [1:0]  col_cnt;
  logic [95:0] asm_q;
  logic        accept;
  logic        take;   // accepted and not cancelled by clear
  logic        load;   // completing beat: move the state into the output buffer

  // Only the completing beat needs a free output slot; columns 0..2 land in
  // asm_q and can be accepted while the output is stalled.
  assign in_ready = (col_cnt != 2'd3) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign take     = accept && !clear;
  assign load     = take && (col_cnt == 2'd3);

  // Column counter.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of the
  // order in which the simulator evaluates the processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= 2'd0;
    end else if (clear) begin
      col_cnt <= 2'd0;
    end else if (accept) begin
      col_cnt <= col_cnt + 2'd1;   // wraps from 3 to 0 on the completing beat
    end
  end

  // Assembly register for columns 0..2; column 0 occupies the top word.
  // NOTE: asm_q has no reset on purpose: it is only ever read together with
  // a col_cnt that proves it was freshly written, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (take) begin
      case (col_cnt)
        2'd0:    asm_q[95:64] <= in_data[39:8];
        2'd1:    asm_q[63:32] <= in_data[39:8];
        2'd2:    asm_q[31:0]  <= in_data[39:8];
        default: asm_q        <= asm_q;
      endcase
    end
  end

  // One-entry output buffer. A reload in the same cycle as a drain keeps
  // out_valid high and replaces the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_state <= {asm_q, in_data[39:8]};
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef XOR_PAD_CHECK_EN
  logic pad_bad;
  logic err_acc;
  logic pad_err_q;

  assign pad_bad = |in_data[7:0];

  // Sticky over the beats of one state; restarts with each new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc <= 1'b0;
    end else if (clear || load) begin
      err_acc <= 1'b0;
    end else if (accept && pad_bad) begin
      err_acc <= 1'b1;
    end
  end

  // Loaded with the state so it stays stable for as long as out_state does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_err_q <= 1'b0;
    end else if (load) begin
      pad_err_q <= err_acc | pad_bad;
    end
  end

  assign out_pad_err = pad_err_q;
`else
  // Pad lane is deliberately ignored in this build.
  logic pad_unused;
  assign pad_unused  = ^in_data[7:0];
  assign out_pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_xor_result_collector.sv
// -----------------------------------------------------------------------------
// tb_xor_result_collector
//
// Directed bench for xor_result_collector: reset state, basic assembly, output
// stall, pad-byte checking (expectation follows XOR_PAD_CHECK_EN), clear,
// asynchronous reset mid-block and with a state pending, and a 16-state stream
// with random out_ready checked against a queue of expected states.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge (or just after it), away from the active rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_xor_result_collector;

`ifdef XOR_PAD_CHECK_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [39:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         out_pad_err;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];

  xor_result_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .out_pad_err (out_pad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one beat starting at a falling edge; returns at the falling edge
  // after the accepting rising edge with in_valid dropped.
  task automatic send(input logic [31:0] w, input logic [7:0] pad);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = {w, pad};
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_state(input logic [127:0] s, input logic [7:0] pad1);
    send(s[127:96], 8'h00);
    send(s[95:64],  pad1);
    send(s[63:32],  8'h00);
    send(s[31:0],   8'h00);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_state"}, out_state, 128'h0);
    check({tag, "_ready"}, in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [127:0] S_BASIC = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] S_A     = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] S_B     = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] S_P     = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] S_C     = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  initial begin
    logic [127:0] s;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check("rst_ready",   in_ready,    1'b1);
    check("rst_valid",   out_valid,   1'b0);
    check("rst_state",   out_state,   128'h0);
    check("rst_pad_err", out_pad_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic assembly, back to back.
    send(32'h00112233, 8'h00);
    send(32'h44556677, 8'h00);
    check("basic_not_early", out_valid, 1'b0);
    send(32'h8899AABB, 8'h00);
    send(32'hCCDDEEFF, 8'h00);
    check("basic_valid",   out_valid,   1'b1);
    check("basic_state",   out_state,   S_BASIC);
    check("basic_pad_err", out_pad_err, 1'b0);
    @(negedge clk);
    check("basic_drained", out_valid, 1'b0);

    // Stall: state A held while B's first three columns stream in.
    out_ready = 1'b0;
    send_state(S_A, 8'h00);
    check("stall_a_valid", out_valid, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1 check("stall_col_ready", in_ready, 1'b1);
      send(S_B[127-32*c -: 32], 8'h00);
    end
    in_valid = 1'b1;
    in_data  = {S_B[31:0], 8'h00};
    #1 check("stall_beat3_blocked", in_ready, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("stall_hold_valid", out_valid, 1'b1);
    check("stall_hold_state", out_state, S_A);
    check("stall_hold_ready", in_ready,  1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("stall_release_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_b_valid", out_valid, 1'b1);
    check("stall_b_state", out_state, S_B);
    @(negedge clk);
    check("stall_b_drained", out_valid, 1'b0);

    // Pad error on beat 1, then a clean state.
    send_state(S_P, 8'h5A);
    check("pad_state",   out_state,   S_P);
    check("pad_err_set", out_pad_err, PAD_EN);
    send_state(S_C, 8'h00);
    check("pad_clean_state", out_state,   S_C);
    check("pad_err_clear",   out_pad_err, 1'b0);
    @(negedge clk);

    // clear: two stale beats (one with a bad pad), a cleared beat, four fresh.
    send(32'h11111111, 8'hFF);
    send(32'h22222222, 8'h00);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = {32'h33333333, 8'h77};
    @(posedge clk);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      send(S_BASIC[127-32*c -: 32], 8'h00);
      check("clear_no_early_out", out_valid, 1'b0);
    end
    send(S_BASIC[31:0], 8'h00);
    check("clear_valid",   out_valid,   1'b1);
    check("clear_state",   out_state,   S_BASIC);
    check("clear_pad_err", out_pad_err, 1'b0);
    @(negedge clk);
    check("clear_single_out", out_valid, 1'b0);

    // Reset mid-block, then a clean state.
    send(32'h99999999, 8'h5A);
    send(32'h88888888, 8'h00);
    async_reset("rst_mid");
    send_state(S_A, 8'h00);
    check("rst_mid_state",   out_state,   S_A);
    check("rst_mid_pad_err", out_pad_err, 1'b0);
    @(negedge clk);

    // Reset with a state pending in the output buffer.
    out_ready = 1'b0;
    send_state(S_B, 8'h00);
    check("rst_pend_valid_before", out_valid, 1'b1);
    async_reset("rst_pend");
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_pend_stays_idle", out_valid, 1'b0);

    // Stream 16 states with random out_ready.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          s = {$urandom(), $urandom(), $urandom(), $urandom()};
          exp_q.push_back(s);
          send_state(s, 8'h00);
        end
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 16 && cyc < 4000) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          #1;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("stream_extra", 1'b1, 1'b0);
            else check("stream_state", out_state, exp_q.pop_front());
            got++;
          end
          cyc++;
        end
        check("stream_count", got, 16);
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("stream_idle", out_valid, 1'b0);
    check("stream_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
